// File: rtl/moving_average_ctrl.sv
// Capture sequencer for one moving_average decimator: gates ADC samples into whole blocks
// and registers filter results. Define AVG_CTRL_DROP_CNT_EN to add the drop_cnt port.
module moving_average_ctrl #(
  parameter int BITS_ADC  = 8,
  parameter int BITS_ACUM = 12,
  parameter int CNT_W     = 16,
  localparam int BIT_DIFF = BITS_ACUM - BITS_ADC,
  localparam int KW       = $clog2(BIT_DIFF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [KW-1:0]       k_req,
  input  logic [CNT_W-1:0]    num_out,
  input  logic [BITS_ADC-1:0] adc_sample,
  input  logic                adc_rdy,
  output logic                filt_rst,
  output logic [KW-1:0]       filt_k,
  output logic [BITS_ADC-1:0] filt_sample,
  output logic                filt_rdy,
  input  logic [BITS_ADC-1:0] filt_sample_in,
  input  logic                filt_rdy_in,
  output logic [BITS_ADC-1:0] sample_out,
  output logic                rdy_out,
  output logic                busy,
`ifdef AVG_CTRL_DROP_CNT_EN
  output logic [15:0]         drop_cnt,
`endif
  output logic                done
);

  // Wide enough for DF-1 at the largest k representable in KW bits.
  localparam int IW = 1 << KW;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_WAIT, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] n_reg;
  logic [CNT_W-1:0] blk_cnt;
  logic [IW-1:0]    in_cnt;
  logic [1:0]       wait_cnt;
  logic [IW-1:0]    df_m1;
  logic             blk_end;
  logic             last_blk;
  logic             fwd;

  // filt_k doubles as the latched k for the whole capture.
  always_comb begin
    df_m1    = IW'((1 << filt_k) - 1);
    blk_end  = (in_cnt == df_m1);
    last_blk = (n_reg != '0) && ((blk_cnt + CNT_W'(1)) == n_reg);
    fwd      = (state == S_RUN) && adc_rdy && !stop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      filt_rst    <= 1'b1;
      filt_k      <= '0;
      filt_sample <= '0;
      filt_rdy    <= 1'b0;
      sample_out  <= '0;
      rdy_out     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      n_reg       <= '0;
      blk_cnt     <= '0;
      in_cnt      <= '0;
      wait_cnt    <= '0;
    end else begin
      rdy_out  <= 1'b0;
      done     <= 1'b0;
      filt_rdy <= 1'b0;

      if (((state == S_RUN) || (state == S_WAIT)) && filt_rdy_in) begin
        rdy_out    <= 1'b1;
        sample_out <= filt_sample_in;
      end

      case (state)
        S_IDLE: begin
          filt_rst <= 1'b1;
          if (start) begin
            filt_k <= k_req;
            n_reg  <= num_out;
            busy   <= 1'b1;
            state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          in_cnt  <= '0;
          blk_cnt <= '0;
          if (stop) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            filt_rst <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          // stop outranks a block completing in the same cycle
          if (stop) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else if (adc_rdy) begin
            filt_rdy    <= 1'b1;
            filt_sample <= adc_sample;
            if (blk_end) begin
              in_cnt  <= '0;
              blk_cnt <= blk_cnt + CNT_W'(1);
              if (last_blk) begin
                wait_cnt <= '0;
                state    <= S_WAIT;
              end
            end else begin
              in_cnt <= in_cnt + IW'(1);
            end
          end
        end
        S_WAIT: begin
          if (stop || filt_rdy_in || (wait_cnt == 2'd3)) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_DONE: begin
          done     <= 1'b1;
          filt_rst <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AVG_CTRL_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if ((state == S_IDLE) && start) begin
      drop_cnt <= '0;
    end else if (adc_rdy && !fwd && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_moving_average_ctrl.sv
// Bench for moving_average_ctrl with a behavioural decimating filter and an output scoreboard.
module tb_moving_average_ctrl;
  localparam int BA = 8;
  localparam int KW = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [KW-1:0] k_req = '0;
  logic [CW-1:0] num_out = '0;
  logic [BA-1:0] adc_sample = '0;
  logic          adc_rdy = 1'b0;
  logic          filt_rst, filt_rdy, rdy_out, busy, done;
  logic [KW-1:0] filt_k;
  logic [BA-1:0] filt_sample, sample_out;
  logic [BA-1:0] filt_sample_in = '0;
  logic          filt_rdy_in = 1'b0;
`ifdef AVG_CTRL_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  always #5 clk = ~clk;

  moving_average_ctrl #(.BITS_ADC(BA), .BITS_ACUM(12), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .k_req(k_req), .num_out(num_out),
    .adc_sample(adc_sample), .adc_rdy(adc_rdy), .filt_rst(filt_rst), .filt_k(filt_k),
    .filt_sample(filt_sample), .filt_rdy(filt_rdy), .filt_sample_in(filt_sample_in),
    .filt_rdy_in(filt_rdy_in), .sample_out(sample_out), .rdy_out(rdy_out), .busy(busy),
`ifdef AVG_CTRL_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .done(done)
  );

  // Decimating filter: averages 1<<k samples, result one cycle after the last sample.
  logic [11:0] f_acc = '0;
  logic [4:0]  f_cnt = '0;
  logic [4:0]  f_df = 5'd1;
  always @(posedge clk) begin
    filt_rdy_in <= 1'b0;
    if (filt_rst) begin
      f_acc <= '0;
      f_cnt <= '0;
      f_df  <= 5'(1 << filt_k);
    end else if (filt_rdy) begin
      if (f_cnt == f_df - 5'd1) begin
        filt_sample_in <= 8'((f_acc + 12'(filt_sample)) >> filt_k);
        filt_rdy_in    <= 1'b1;
        f_acc          <= '0;
        f_cnt          <= '0;
      end else begin
        f_acc <= f_acc + 12'(filt_sample);
        f_cnt <= f_cnt + 5'd1;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_seen = 0, done_seen = 0, fr_seen = 0;
  int last_rdy_cyc = 0, done_cyc = 0;
  logic [BA-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops the scoreboard on every rdy_out, tracks done and filt_rdy pulses.
  always @(negedge clk) begin
    if (rdy_out) begin
      rdy_seen++;
      last_rdy_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected rdy_out: got 0x%0h required no output", sample_out);
      end else begin
        chk("sample_out", int'(sample_out), int'(exp_q.pop_front()));
      end
    end
    if (done) begin
      done_seen++;
      done_cyc = cyc;
    end
    if (filt_rdy) fr_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap_start(input int k, input int n);
    start   = 1'b1;
    k_req   = KW'(k);
    num_out = CW'(n);
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic strobe(input logic [BA-1:0] s);
    adc_rdy    = 1'b1;
    adc_sample = s;
    tick();
    adc_rdy = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_seen;
    int n = 0;
    while (done_seen == d0 && n < 40) begin
      tick();
      n++;
    end
    chk(name, done_seen - d0, 1);
    chk({name, " queue drained"}, exp_q.size(), 0);
    chk({name, " filt_rst idle"}, int'(filt_rst), 1);
    chk({name, " busy idle"}, int'(busy), 0);
  endtask

  task automatic chk_reset(input string name);
    chk({name, " filt_rst"}, int'(filt_rst), 1);
    chk({name, " filt_k"}, int'(filt_k), 0);
    chk({name, " filt_sample"}, int'(filt_sample), 0);
    chk({name, " filt_rdy"}, int'(filt_rdy), 0);
    chk({name, " sample_out"}, int'(sample_out), 0);
    chk({name, " rdy_out"}, int'(rdy_out), 0);
    chk({name, " busy"}, int'(busy), 0);
    chk({name, " done"}, int'(done), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr0, r0, d0;
    logic [BA-1:0] v;
    repeat (2) tick();
    chk_reset("reset");
    rst = 1'b1;
    tick();

    // Basic: DF=4, three blocks of 0x10.
    fr0 = fr_seen;
    repeat (3) exp_q.push_back(8'h10);
    cap_start(2, 3);
    chk("basic filt_k", int'(filt_k), 2);
    chk("basic busy", int'(busy), 1);
    chk("basic filt_rst run", int'(filt_rst), 0);
    repeat (12) strobe(8'h10);
    wait_done("basic done");
    chk("basic filt_rdy count", fr_seen - fr0, 12);
    chk("basic done gap", done_cyc - last_rdy_cyc, 1);

    // Gating: DF=2, two blocks, last two strobes land in WAIT.
    fr0 = fr_seen;
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h20);
    cap_start(1, 2);
    strobe(8'h20); strobe(8'h40); strobe(8'h10); strobe(8'h30); strobe(8'hFF); strobe(8'hFF);
    wait_done("gating done");
    chk("gating filt_rdy count", fr_seen - fr0, 4);
`ifdef AVG_CTRL_DROP_CNT_EN
    chk("gating drop_cnt", int'(drop_cnt), 2);
`endif

    // Abort in continuous mode, then a DF=1 capture.
    r0 = rdy_seen;
    cap_start(3, 0);
    repeat (5) strobe(8'h11);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("abort done");
    chk("abort no output", rdy_seen - r0, 0);
    exp_q.push_back(8'h55);
    cap_start(0, 1);
    strobe(8'h55);
    wait_done("k0 done");

    // Reconfiguration and start ignored during RUN.
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h50);
    cap_start(1, 2);
    strobe(8'h10); strobe(8'h30);
    k_req = 2'd3;
    num_out = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("reconf filt_k held", int'(filt_k), 1);
    chk("reconf busy", int'(busy), 1);
    strobe(8'h40); strobe(8'h60);
    wait_done("reconf done");
    fr0 = fr_seen;
    exp_q.push_back(8'h04);
    cap_start(3, 1);
    chk("reconf new filt_k", int'(filt_k), 3);
    for (int i = 1; i <= 8; i++) begin
      v = BA'(i);
      strobe(v);
    end
    wait_done("df8 done");
    chk("df8 filt_rdy count", fr_seen - fr0, 8);

    // Stop coincides with the final block completing.
    r0 = rdy_seen;
    cap_start(1, 1);
    strobe(8'h80);
    adc_rdy = 1'b1;
    adc_sample = 8'h80;
    stop = 1'b1;
    tick();
    adc_rdy = 1'b0;
    stop = 1'b0;
    wait_done("collide done");
    repeat (4) tick();
    chk("collide no output", rdy_seen - r0, 0);

    // Asynchronous reset mid-RUN.
    cap_start(2, 0);
    repeat (3) strobe(8'h33);
    d0 = done_seen;
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_reset("midrun reset");
    repeat (2) tick();
    rst = 1'b1;
    repeat (6) tick();
    chk("midrun no done", done_seen - d0, 0);
    chk("midrun busy", int'(busy), 0);
    chk("midrun queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
